// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// frame field widths and the default frame start byte.
package boot_pkg;

    localparam int LEN_W = 16;
    localparam int CHK_W = 8;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    // States in which the loader still expects stream bytes.
    function automatic logic state_accepts(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_LEN_HI) || (st == ST_LEN_LO) ||
               (st == ST_DATA) || (st == ST_CHECK);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs big-endian payload bytes into 32-bit words and emits a one-cycle
// strobe with the completed word held stable until the next word completes.
module word_assembler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o,
    output logic [1:0]  byte_cnt_o
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (byte_valid_i) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
                word_d       = {shift_q, byte_i};
                word_valid_d = 1'b1;
            end else begin
                shift_d = {shift_q[15:0], byte_i};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;
    assign byte_cnt_o   = byte_cnt_q;

endmodule

// File: rtl/im_boot_loader.sv
// Loads a framed, checksummed program image into instruction memory and
// releases the CPU from reset only once the whole image has verified.
module im_boot_loader
    import boot_pkg::*;
#(
    parameter int         IM_DEPTH = 1024,
    parameter int         ADDR_W   = 10,
    parameter logic [7:0] MAGIC    = MAGIC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    logic [2:0]        state_q, state_d;
    logic              rx_ready_q, rx_ready_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [CHK_W-1:0]  chk_q, chk_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;

    logic        fire;
    logic        data_fire;
    logic [1:0]  byte_cnt;
    logic        word_valid;
    logic [31:0] word;
    logic [31:0] len_lo_ext;
    logic        last_word;

    assign fire       = rx_valid && rx_ready_q;
    assign data_fire  = fire && (state_q == ST_DATA);
    assign len_lo_ext = {16'd0, len_q[15:8], rx_data};
    assign last_word  = ({{(32-ADDR_W){1'b0}}, word_idx_q} == ({16'd0, len_q} - 32'd1));

    word_assembler u_word_assembler (
        .clk_i        (clock),
        .rst_ni       (reset),
        .byte_valid_i (data_fire),
        .byte_i       (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word),
        .byte_cnt_o   (byte_cnt)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        chk_d      = chk_q;
        im_addr_d  = im_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (fire && (rx_data == MAGIC)) begin
                    state_d    = ST_LEN_HI;
                    chk_d      = '0;
                    word_idx_d = '0;
                end
            end
            ST_LEN_HI: begin
                if (fire) begin
                    len_d[15:8] = rx_data;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (fire) begin
                    len_d[7:0] = rx_data;
                    if (len_lo_ext > 32'(IM_DEPTH)) begin
                        state_d = ST_ERROR;
                    end else if (len_lo_ext == 32'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (fire) begin
                    chk_d = chk_q ^ rx_data;
                    if (byte_cnt == 2'd3) begin
                        // Address is latched alongside the word so both stay put between pulses.
                        im_addr_d = word_idx_q;
                        if (last_word) begin
                            state_d = ST_CHECK;
                        end else begin
                            word_idx_d = word_idx_q + 1'b1;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (fire) begin
                    state_d = (rx_data == chk_q) ? ST_RUN : ST_ERROR;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        rx_ready_d = state_accepts(state_d);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rx_ready_q <= 1'b0;
            len_q      <= '0;
            word_idx_q <= '0;
            chk_q      <= '0;
            im_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            chk_q      <= chk_d;
            im_addr_q  <= im_addr_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign im_we     = word_valid;
    assign im_addr   = im_addr_q;
    assign im_wdata  = word;
    assign cpu_reset = (state_q == ST_RUN);
    assign done      = (state_q == ST_RUN);
    assign error     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_im_boot_loader.sv
// Directed checks of the boot loader: nominal load, bad checksum, garbage and
// stalls, length limits, reset during a load and a full-depth image.
module tb_im_boot_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    im_boot_loader #(.IM_DEPTH(DEPTH), .ADDR_W(AW), .MAGIC(8'hA5)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_fail = 0;
    int            we_count = 0;
    int            seq_err = 0;
    int            last_addr = -1;
    int            base;
    logic [AW-1:0] exp_addr = '0;
    logic [31:0]   tb_mem [0:DEPTH-1];
    logic [7:0]    frame [$];

    // Write monitor: records every pulse and flags out-of-order addresses.
    always @(negedge clock) begin
        if (!reset) begin
            exp_addr = '0;
        end else if (im_we) begin
            if (im_addr != exp_addr) seq_err++;
            tb_mem[im_addr] = im_wdata;
            last_addr = int'(im_addr);
            we_count++;
            exp_addr = exp_addr + 1'b1;
            $display("write addr=%0d data=%08h", im_addr, im_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        guard    = 0;
        while (!rx_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!rx_ready) begin
            check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic stall(input int n);
        @(negedge clock);
        rx_valid = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic send_frame(input bit with_stalls);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            if (with_stalls && i != frame.size() - 1) stall((i % 5) + 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic load_nominal(input logic [7:0] chk);
        frame = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h0A,
                  8'h00, 8'h22, 8'h18, 8'h07, 8'h00};
        frame[11] = chk;
    endtask

    initial begin
        // Reset state
        @(posedge clock);
        #1;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_im_we", {31'd0, im_we}, 32'd0);
        check("rst_im_addr", {22'd0, im_addr}, 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Nominal load
        base = we_count;
        load_nominal(8'h16);
        send_frame(1'b0);
        check("nom_done", {31'd0, done}, 32'd1);
        check("nom_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("nom_error", {31'd0, error}, 32'd0);
        check("nom_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("nom_writes", 32'(we_count - base), 32'd2);
        check("nom_mem0", tb_mem[0], 32'h2001000a);
        check("nom_mem1", tb_mem[1], 32'h00221807);
        check("nom_last_addr", 32'(last_addr), 32'd1);

        // Bad checksum
        do_reset();
        base = we_count;
        load_nominal(8'h17);
        send_frame(1'b0);
        check("bad_error", {31'd0, error}, 32'd1);
        check("bad_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("bad_done", {31'd0, done}, 32'd0);
        check("bad_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("bad_writes", 32'(we_count - base), 32'd2);

        // Garbage bytes and stalls
        do_reset();
        base = we_count;
        send_byte(8'h00); stall(3);
        send_byte(8'hFF); stall(1);
        send_byte(8'h5A); stall(5);
        check("garbage_no_write", 32'(we_count - base), 32'd0);
        check("garbage_done", {31'd0, done}, 32'd0);
        load_nominal(8'h16);
        send_frame(1'b1);
        check("stall_done", {31'd0, done}, 32'd1);
        check("stall_writes", 32'(we_count - base), 32'd2);
        check("stall_mem0", tb_mem[0], 32'h2001000a);
        check("stall_mem1", tb_mem[1], 32'h00221807);

        // Empty image
        do_reset();
        base = we_count;
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        check("n0_done", {31'd0, done}, 32'd1);
        check("n0_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("n0_writes", 32'(we_count - base), 32'd0);

        // Oversized image rejected right after the length
        do_reset();
        frame = '{8'hA5, 8'h04, 8'h01};
        send_frame(1'b0);
        check("big_error", {31'd0, error}, 32'd1);
        check("big_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("big_cpu_reset", {31'd0, cpu_reset}, 32'd0);

        // Word completion coinciding with reset produces no write
        do_reset();
        base = we_count;
        frame = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00};
        send_frame(1'b0);
        @(negedge clock);
        rx_data  = 8'h0A;
        rx_valid = 1'b1;
        reset    = 1'b0;
        @(posedge clock);
        #1;
        check("sup_im_we", {31'd0, im_we}, 32'd0);
        check("sup_rx_ready", {31'd0, rx_ready}, 32'd0);
        @(negedge clock);
        rx_valid = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clock);
        check("sup_writes", 32'(we_count - base), 32'd0);

        // Reset in the middle of word 1, then full reload
        base = we_count;
        frame = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h0A, 8'h00, 8'h22};
        send_frame(1'b0);
        stall(3);
        check("mid_writes", 32'(we_count - base), 32'd1);
        check("mid_addr", 32'(last_addr), 32'd0);
        do_reset();
        check("mid_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        load_nominal(8'h16);
        send_frame(1'b0);
        check("mid_done", {31'd0, done}, 32'd1);
        check("mid_total_writes", 32'(we_count - base), 32'd3);
        check("mid_mem1", tb_mem[1], 32'h00221807);

        // Full-depth image with a counting payload (XOR over 16 x 0..255 is 0)
        do_reset();
        base = we_count;
        frame = '{8'hA5, 8'h04, 8'h00};
        for (int k = 0; k < 4 * DEPTH; k++) frame.push_back(k[7:0]);
        frame.push_back(8'h00);
        send_frame(1'b0);
        check("full_done", {31'd0, done}, 32'd1);
        check("full_error", {31'd0, error}, 32'd0);
        check("full_writes", 32'(we_count - base), 32'd1024);
        check("full_last_addr", 32'(last_addr), 32'd1023);
        check("full_mem0", tb_mem[0], 32'h00010203);
        check("full_mem5", tb_mem[5], 32'h14151617);
        check("full_mem1023", tb_mem[1023], 32'hfcfdfeff);
        check("addr_sequence", 32'(seq_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
- Upstream feeder for the single-cycle CPU.
- Accepts a framed byte stream (valid/ready) carrying a program image and writes it word-by-word into the CPU instruction memory (word-indexed).
- Holds the CPU in reset until the full image is loaded and its checksum verifies, then releases the CPU.
- Replaces hierarchical pre-loading of instruction memory in system-level benches.

Parameters:
- IM_DEPTH, 1024, instruction memory depth in 32-bit words.
- ADDR_W, 10, width of the word address; must satisfy 2**ADDR_W >= IM_DEPTH.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready at a rising edge.
- im_we  out  1  instruction memory write enable, one-cycle pulse per word.
- im_addr  out  ADDR_W  word address of the write.
- im_wdata  out  32  instruction word.
- cpu_reset  out  1  active-low reset to the CPU; 0 holds it in reset.
- done  out  1  image loaded and verified; CPU running.
- error  out  1  frame rejected; sticky until reset.

Behaviour:
- Reset (reset==0 at an edge) produces the following:
  - state=IDLE.
  - rx_ready=0 in the reset cycle, 1 afterwards.
  - im_we=0, im_addr=0, im_wdata=0.
  - cpu_reset=0, done=0, error=0.
  - Word counter, byte counter and checksum cleared.
- Frame format (all fields MSB first):
  - MAGIC.
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N words of 4 bytes each, big-endian.
  - CHK: XOR of all 4N payload bytes; the initial value is 0x00.
- FSM states:
  - IDLE: rx_ready=1. Accepted byte == MAGIC -> LEN_HI. Any other byte is discarded and the FSM stays in IDLE.
  - LEN_HI: store the high byte -> LEN_LO.
  - LEN_LO: store the low byte, then:
    - N > IM_DEPTH -> ERROR.
    - N == 0 -> CHECK.
    - Otherwise -> DATA.
  - DATA: shift the accepted byte into the word assembly register and XOR it into the checksum.
    - On the 4th byte of a word, im_we=1 in the next cycle with im_addr=word index and im_wdata=the assembled word. The word index then increments.
    - After the 4th byte of word N-1 -> CHECK.
  - CHECK: compare the accepted byte with the running checksum.
    - Equal -> RUN.
    - Different -> ERROR.
  - RUN: rx_ready=0, cpu_reset=1, done=1. These are first asserted in the cycle after CHK is accepted. The FSM stays here until reset.
  - ERROR: rx_ready=0, cpu_reset=0, error=1. The FSM stays here until reset.
- Handshake:
  - While rx_valid=0, no state, counter or checksum changes.
  - rx_ready is a registered function of state only and never depends on rx_valid.
  - Stalls of any length between bytes are legal.
- im_we:
  - At most one pulse per 4 accepted payload bytes; back-to-back pulses are legal at full byte rate.
  - im_addr and im_wdata are held stable outside pulses.
- Words already written before an ERROR or a mid-load reset stay in instruction memory; the loader never clears memory.
- Reset mid-operation:
  - Partial word, length and checksum are discarded.
  - The CPU remains held in reset.
  - The next frame must begin with MAGIC.
- An im_we pulse due in the same cycle as reset asserts is suppressed.
- Word index is width ADDR_W. N == IM_DEPTH is legal: the last address written is IM_DEPTH-1, and the index never wraps to 0 within a frame.

Decomposition:
- Shared package `boot_pkg` holds:
  - FSM state encoding: IDLE, LEN_HI, LEN_LO, DATA, CHECK, RUN, ERROR.
  - The MAGIC default.
  - Frame field widths: LEN 16, CHK 8.
- Sub-module `word_assembler` covers:
  - The byte counter (0..3).
  - The 32-bit shift register.
  - A one-cycle word_valid strobe.
- The FSM, checksum and address counter stay in the top.

Test Plan:
- Nominal load: stream A5 00 02 20 01 00 0A 00 22 18 07 16.
  - Expected writes: im_addr 0 <- 32'h2001000a, then im_addr 1 <- 32'h00221807.
  - done=1 and cpu_reset=1 one cycle after 0x16 is accepted.
  - With GPR[2] preset to 32'hffffffff and 100 cycles of CPU run, GPR[1]=10 and GPR[3]=32'hffffffff.
- Bad checksum: same frame with CHK=0x17.
  - Two writes still occur.
  - error=1, cpu_reset stays 0, done=0, rx_ready=0.
- Garbage and stalls:
  - Stimulus: 00 FF 5A before A5; rx_valid toggled low for 1-5 cycles between bytes.
  - Expected: the same writes and result as the nominal case.
  - No im_we pulse during the garbage bytes or during stalls.
- Length limits:
  - N=0 (A5 00 00 00) -> done=1 with no im_we pulse.
  - N=IM_DEPTH+1 (A5 04 01) -> error=1 immediately after LEN_LO is accepted.
- Reset mid-load: assert reset after 2 payload bytes of word 1 of the nominal frame, then resend the full frame.
  - Exactly one write at im_addr 0 occurs before the reset.
  - The final result matches the nominal case.
- Full depth: N=1024 with a counting-pattern payload.
  - Last write at im_addr 1023.
  - No address wrap.
  - Checksum verified and done=1.
